// File: rtl/qerv_mem_seq_pkg.sv
// Shared types for the load/store sequencer: state encoding, size codes
// and the Wishbone byte-lane select helper.
package qerv_mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_REQ,
        ST_SHIFT,
        ST_DONE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Half at lsb=3 shifts its upper lane out: the access is truncated.
    function automatic logic [3:0] wb_sel(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic [3:0] sel;
        case (size)
            SZ_BYTE: sel = 4'b0001 << lsb;
            SZ_HALF: sel = 4'b0011 << lsb;
            default: sel = 4'hF;
        endcase
        return sel;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lsb
    );
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lsb[0];
            default: m = (lsb != 2'd0);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/qerv_mem_seq_if.sv
// Wishbone data-bus handshake between the sequencer (master) and memory.
interface qerv_mem_seq_if;

    logic       cyc;
    logic       we;
    logic [3:0] sel;
    logic       ack;

    modport master (
        output cyc,
        output we,
        output sel,
        input  ack
    );

    modport slave (
        input  cyc,
        input  we,
        input  sel,
        output ack
    );

endinterface

// File: rtl/qerv_mem_seq_byte_valid.sv
// Marks which serial bit positions of a load fall inside the accessed
// bytes; positions beyond are sign/zero filled downstream.
module qerv_byte_valid_gen
    import qerv_mem_seq_pkg::*;
#(
    parameter int W  = 1,
    parameter int CW = $clog2(32 / W)
) (
    input  logic [CW-1:0] i_cnt,
    input  logic [1:0]    i_size,
    output logic          o_byte_valid
);

    logic [5:0] bit_idx;
    logic [5:0] limit;

    assign bit_idx = 6'(i_cnt) * 6'(W);

    always_comb begin
        limit = 6'd32;
        case (i_size)
            SZ_BYTE: limit = 6'd8;
            SZ_HALF: limit = 6'd16;
            default: limit = 6'd32;
        endcase
    end

    assign o_byte_valid = (bit_idx < limit);

endmodule

// File: rtl/qerv_mem_seq.sv
// Load/store sequencer driving bufreg2 controls and the Wishbone data bus.
// Optional misaligned-access trap: define QERV_MISALIGN_TRAP_EN.
module qerv_mem_seq
    import qerv_mem_seq_pkg::*;
#(
    parameter int W  = 1,
    parameter int CW = $clog2(32 / W)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_we,
    input  logic [1:0]         i_size,
    input  logic [1:0]         i_lsb,
    output logic               o_init,
    output logic               o_en,
    output logic               o_byte_valid,
    output logic               o_load,
    output logic [1:0]         o_lsb,
    qerv_mem_seq_if.master     wb,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_misalign
);

    localparam logic [CW-1:0] LAST = CW'(32 / W - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [1:0]    lsb_q, lsb_d;
    logic          mis_q, mis_d;
    logic          shift_bv;

    qerv_byte_valid_gen #(
        .W  (W),
        .CW (CW)
    ) u_bv (
        .i_cnt        (cnt_q),
        .i_size       (size_q),
        .o_byte_valid (shift_bv)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            lsb_q   <= 2'd0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            lsb_q   <= lsb_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        size_d       = size_q;
        lsb_d        = lsb_q;
        mis_d        = mis_q;
        o_init       = 1'b0;
        o_en         = 1'b0;
        o_byte_valid = 1'b0;
        o_load       = 1'b0;
        wb.cyc       = 1'b0;
        wb.we        = 1'b0;
        wb.sel       = 4'h0;
        o_done       = 1'b0;
        o_misalign   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                mis_d = 1'b0;
                if (i_start) begin
                    we_d   = i_we;
                    size_d = i_size;
                    lsb_d  = i_lsb;
`ifdef QERV_MISALIGN_TRAP_EN
                    if (misaligned(i_size, i_lsb)) begin
                        mis_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = i_we ? ST_INIT : ST_REQ;
                    end
`else
                    state_d = i_we ? ST_INIT : ST_REQ;
`endif
                end
            end
            ST_INIT: begin
                o_init       = 1'b1;
                o_en         = 1'b1;
                o_byte_valid = 1'b1;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_REQ;
            end
            ST_REQ: begin
                wb.cyc = 1'b1;
                wb.we  = we_q;
                wb.sel = wb_sel(size_q, lsb_q);
                if (wb.ack) begin
                    o_load  = ~we_q;
                    state_d = we_q ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                o_en         = 1'b1;
                o_byte_valid = shift_bv;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done     = 1'b1;
`ifdef QERV_MISALIGN_TRAP_EN
                o_misalign = mis_q;
`endif
                mis_d      = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_lsb  = lsb_q;
    assign o_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_qerv_mem_seq.sv
// Directed bench for qerv_mem_seq: W=1 and W=4 instances on one clock.
module tb_qerv_mem_seq;
    import qerv_mem_seq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start1, we1, start4, we4;
    logic [1:0] size1, lsb1, size4, lsb4;
    logic       init1, en1, bv1, load1, busy1, done1, mis1;
    logic       init4, en4, bv4, load4, busy4, done4, mis4;
    logic [1:0] olsb1, olsb4;

    qerv_mem_seq_if bus1 ();
    qerv_mem_seq_if bus4 ();

    qerv_mem_seq #(.W(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_we(we1),
        .i_size(size1), .i_lsb(lsb1), .o_init(init1), .o_en(en1),
        .o_byte_valid(bv1), .o_load(load1), .o_lsb(olsb1),
        .wb(bus1.master), .o_busy(busy1), .o_done(done1),
        .o_misalign(mis1)
    );

    qerv_mem_seq #(.W(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(start4), .i_we(we4),
        .i_size(size4), .i_lsb(lsb4), .o_init(init4), .o_en(en4),
        .o_byte_valid(bv4), .o_load(load4), .o_lsb(olsb4),
        .wb(bus4.master), .o_busy(busy4), .o_done(done4),
        .o_misalign(mis4)
    );

    int vecs = 0;
    int errs = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go1(logic we, logic [1:0] sz, logic [1:0] lsb);
        start1 = 1'b1; we1 = we; size1 = sz; lsb1 = lsb;
        tick();
        start1 = 1'b0;
    endtask

    task automatic go4(logic we, logic [1:0] sz, logic [1:0] lsb);
        start4 = 1'b1; we4 = we; size4 = sz; lsb4 = lsb;
        tick();
        start4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start1 = 0; we1 = 0; size1 = 0; lsb1 = 0;
        start4 = 0; we4 = 0; size4 = 0; lsb4 = 0;
        bus1.ack = 1'b0; bus4.ack = 1'b0;
        tick(); tick();
        chk("rst_busy", busy1, 0);
        chk("rst_cyc", bus1.cyc, 0);
        chk("rst_sel", bus1.sel, 0);
        chk("rst_ctl", {init1, en1, bv1, load1, done1, mis1}, 0);
        chk("rst_lsb", olsb1, 0);
        chk("rst_busy4", busy4, 0);
        rst = 1'b0;

        // stray ack while idle
        bus1.ack = 1'b1;
        tick();
        chk("idle_ack", {busy1, bus1.cyc}, 0);
        bus1.ack = 1'b0;

        // store word, lsb 0
        go1(1'b1, SZ_WORD, 2'd0);
        for (int i = 0; i < 32; i++) begin
            chk("st_init", {init1, en1, bv1, bus1.cyc}, 4'b1110);
            tick();
        end
        chk("st_req", {bus1.cyc, bus1.we, init1}, 3'b110);
        chk("st_sel", bus1.sel, 4'hF);
        tick(); tick();
        chk("st_hold", bus1.cyc, 1);
        bus1.ack = 1'b1;
        #1;
        chk("st_noload", load1, 0);
        tick();
        bus1.ack = 1'b0;
        chk("st_done", {done1, busy1, bus1.cyc}, 3'b110);
        tick();
        chk("st_idle", {done1, busy1}, 0);

        // load byte, lsb 2
        go1(1'b0, SZ_BYTE, 2'd2);
        chk("lb_sel", bus1.sel, 4'b0100);
        chk("lb_we", {bus1.cyc, bus1.we}, 2'b10);
        chk("lb_lsb", olsb1, 2'd2);
        bus1.ack = 1'b1;
        #1;
        chk("lb_load", load1, 1);
        tick();
        bus1.ack = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("lb_shift", {en1, bv1, load1, bus1.cyc},
                {1'b1, (i < 8), 2'b00});
            tick();
        end
        chk("lb_done", done1, 1);
        chk("lb_lsb_hold", olsb1, 2'd2);
        tick();
        chk("lb_idle", busy1, 0);

        // load half on the 4-bit datapath
        go4(1'b0, SZ_HALF, 2'd0);
        chk("lh_sel", bus4.sel, 4'b0011);
        bus4.ack = 1'b1;
        #1;
        chk("lh_load", load4, 1);
        tick();
        bus4.ack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("lh_shift", {en4, bv4}, {1'b1, (i < 4)});
            tick();
        end
        chk("lh_done", {done4, en4}, 2'b10);
        tick();
        chk("lh_idle", busy4, 0);

        // reset while the bus request is outstanding
        go1(1'b0, SZ_WORD, 2'd0);
        chk("ab_cyc", bus1.cyc, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ab_state", {bus1.cyc, busy1, done1}, 0);
        tick();
        chk("ab_nodone", {done1, busy1}, 0);

        // start pulses during SHIFT and DONE are dropped
        go1(1'b0, SZ_WORD, 2'd0);
        bus1.ack = 1'b1;
        tick();
        bus1.ack = 1'b0;
        for (int i = 0; i < 32; i++) begin
            start1 = (i == 5); we1 = 1'b1;
            tick();
        end
        start1 = 1'b0;
        chk("ig_done", done1, 1);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("ig_idle", {busy1, init1, bus1.cyc}, 0);
        tick();
        chk("ig_still", busy1, 0);

        // misaligned accesses go out unchecked
        go1(1'b0, SZ_WORD, 2'd1);
        chk("mw_sel", bus1.sel, 4'hF);
        chk("mw_mis", {bus1.cyc, mis1}, 2'b10);
        rst = 1'b1; tick(); rst = 1'b0;
        go1(1'b0, SZ_HALF, 2'd3);
        chk("mh_sel", bus1.sel, 4'b1000);
        chk("mh_lsb", olsb1, 2'd3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mh_idle", busy1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
